// File: rtl/alu_mdu_control_if.sv
// EX-stage bus between the ID/EX register and the ALU control / multiply-divide unit.
// The master drives instruction fields and operands; the slave returns ALU control and MDU status.
interface alu_mdu_control_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
);
    logic              valid_i;
    logic              flush_i;
    logic [9:0]        Funct_i;
    logic [1:0]        ALUOp_i;
    logic [XLEN-1:0]   rs1_i;
    logic [XLEN-1:0]   rs2_i;
    logic [CTRL_W-1:0] ALUCtrl_o;
    logic              mdu_busy_o;
    logic              mdu_done_o;
    logic [XLEN-1:0]   mdu_result_o;

    modport master (
        output valid_i, flush_i, Funct_i, ALUOp_i, rs1_i, rs2_i,
        input  ALUCtrl_o, mdu_busy_o, mdu_done_o, mdu_result_o
    );

    modport slave (
        input  valid_i, flush_i, Funct_i, ALUOp_i, rs1_i, rs2_i,
        output ALUCtrl_o, mdu_busy_o, mdu_done_o, mdu_result_o
    );
endinterface

// File: rtl/alu_mdu_control.sv
// ALU operation decode plus an iterative one-bit-per-cycle multiply/divide unit that
// stalls the pipeline until its registered result is ready.
module alu_mdu_control #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    alu_mdu_control_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000, OP_XOR = 4'b0001, OP_SLL = 4'b0010, OP_ADD  = 4'b0011,
        OP_SUB  = 4'b0100, OP_SRA = 4'b0101, OP_OR  = 4'b0110, OP_SRL  = 4'b0111,
        OP_SLT  = 4'b1000, OP_SLTU = 4'b1001, OP_MDU = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    alu_op_e   op;
    logic [2:0] f3;
    logic       f8;
    logic       unused_funct;

    assign f3 = bus.Funct_i[2:0];
    assign f8 = bus.Funct_i[8];
    assign unused_funct = ^{bus.Funct_i[9], bus.Funct_i[7:4]};

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        op = OP_ADD;
        if (bus.ALUOp_i == 2'b10) begin
            op = OP_SUB;
        end else if (bus.ALUOp_i == 2'b00 && bus.Funct_i[3]) begin
            op = OP_MDU;
        end else if (bus.ALUOp_i[1] == 1'b0) begin
            case (f3)
                3'b000:  op = (f8 && bus.ALUOp_i == 2'b00) ? OP_SUB : OP_ADD;
                3'b001:  op = OP_SLL;
                3'b010:  op = OP_SLT;
                3'b011:  op = OP_SLTU;
                3'b100:  op = OP_XOR;
                3'b101:  op = f8 ? OP_SRA : OP_SRL;
                3'b110:  op = OP_OR;
                default: op = OP_AND;
            endcase
        end
    end

    assign bus.ALUCtrl_o = CTRL_W'(op);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  a_q, a_d;      // multiplicand or divisor magnitude
    logic [XLEN-1:0]  hi_q, hi_d;    // product high half or partial remainder
    logic [XLEN-1:0]  lo_q, lo_d;    // multiplier / product low half, or dividend / quotient
    logic [2:0]       f3_q, f3_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic            start, is_sdiv, div_zero, div_ovf, last;
    logic [XLEN-1:0] rs1_mag, rs2_mag, special_res;
    logic [XLEN:0]   mul_sum, rem_sh, rem_diff;
    logic [XLEN-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n, quo_fix, rem_fix;

    assign start = (state_q == S_IDLE) && bus.valid_i && (bus.ALUOp_i == 2'b00)
                   && bus.Funct_i[3] && !bus.flush_i;

    assign is_sdiv  = f3[2] && !f3[0];
    assign rs1_mag  = (is_sdiv && bus.rs1_i[XLEN-1]) ? -bus.rs1_i : bus.rs1_i;
    assign rs2_mag  = (is_sdiv && bus.rs2_i[XLEN-1]) ? -bus.rs2_i : bus.rs2_i;
    assign div_zero = f3[2] && (bus.rs2_i == '0);
    assign div_ovf  = is_sdiv && (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_i == '1);
    // Overflow yields quotient = dividend (100..0) and remainder 0.
    assign special_res = div_zero ? (f3[1] ? bus.rs1_i : '1)
                                  : (f3[1] ? '0 : bus.rs1_i);

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    assign mul_hi_n = mul_sum[XLEN:1];
    assign mul_lo_n = {mul_sum[0], lo_q[XLEN-1:1]};

    assign rem_sh   = {hi_q, lo_q[XLEN-1]};
    assign rem_diff = rem_sh - {1'b0, a_q};
    assign div_hi_n = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
    assign div_lo_n = {lo_q[XLEN-2:0], ~rem_diff[XLEN]};
    assign quo_fix  = qneg_q ? -div_lo_n : div_lo_n;
    assign rem_fix  = rneg_q ? -div_hi_n : div_hi_n;

    assign last = (cnt_q == CNT_W'(XLEN - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        f3_d     = f3_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    f3_d  = f3;
                    cnt_d = '0;
                    hi_d  = '0;
                    if (div_zero || div_ovf) begin
                        state_d  = S_DONE;
                        result_d = special_res;
                    end else if (f3[2]) begin
                        state_d = S_DIV;
                        a_d     = rs2_mag;
                        lo_d    = rs1_mag;
                        qneg_d  = is_sdiv && (bus.rs1_i[XLEN-1] ^ bus.rs2_i[XLEN-1]);
                        rneg_d  = is_sdiv && bus.rs1_i[XLEN-1];
                    end else begin
                        state_d = S_MUL;
                        a_d     = bus.rs1_i;
                        lo_d    = bus.rs2_i;
                    end
                end
            end
            S_MUL: begin
                hi_d  = mul_hi_n;
                lo_d  = mul_lo_n;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    state_d  = S_DONE;
                    result_d = (f3_q == 3'b011) ? mul_hi_n : mul_lo_n;
                end
            end
            S_DIV: begin
                hi_d  = div_hi_n;
                lo_d  = div_lo_n;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    state_d  = S_DONE;
                    result_d = f3_q[1] ? rem_fix : quo_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            f3_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            f3_q     <= f3_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign bus.mdu_busy_o   = start || (state_q == S_MUL) || (state_q == S_DIV);
    assign bus.mdu_done_o   = (state_q == S_DONE);
    assign bus.mdu_result_o = result_q;
endmodule

// File: doc/alu_mdu_control.md
# alu_mdu_control

Parametrised EX-stage ALU control with an integrated iterative multiply/divide unit (MDU). Decodes the 10-bit funct field and the 2-bit ALUOp from ID/EX into a 4-bit ALU operation code, and runs RV32M-style MUL/DIV/REM operations as a multi-cycle sequence. It holds the pipeline via a busy/stall output until the result is ready. Sits between the ID/EX register and the ALU/forwarding mux in the pipelined CPU; the hazard unit consumes `mdu_busy_o`.

## Interface
- `XLEN`, 32: operand/result width (≥ 8, even).
- `CTRL_W`, 4: ALUCtrl_o width (fixed encoding below needs ≥ 4).

- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `valid_i` in 1: EX stage holds a valid instruction.
- `flush_i` in 1: synchronous abort of EX (branch/exception).
- `Funct_i` in 10: {funct7, funct3}; bit 8 = funct7[5], bit 3 = funct7[0], bits 2:0 = funct3.
- `ALUOp_i` in 2: 00 R-type, 01 I-type arith, 10 branch, 11 load/store.
- `rs1_i`, `rs2_i` in XLEN: forwarded operands.
- `ALUCtrl_o` out CTRL_W: ALU operation.
- `mdu_busy_o` out 1: stall request to hazard unit.
- `mdu_done_o` out 1: MDU result valid this cycle.
- `mdu_result_o` out XLEN: MDU result.

## Operation
- ALUCtrl codes: AND 0000, XOR 0001, SLL 0010, ADD 0011, SUB 0100, SRA 0101, OR 0110, SRL 0111, SLT 1000, SLTU 1001, MDU 1111.
- Decode is combinational and unaffected by reset:
  - ALUOp 10 gives SUB. ALUOp 11 gives ADD.
  - ALUOp 00 with Funct_i[3]=1 gives MDU.
  - ALUOp 00 with Funct_i[3]=0 decodes funct3: 000 ADD, or SUB if F[8]; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA if F[8]; 110 OR; 111 AND.
  - ALUOp 01 uses the same funct3 map. F[8] is honoured only for 101 (SRAI); 000 is always ADD.
  - Any undefined combination gives ADD.
- MDU funct3 map: 000 MUL (low XLEN), 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU. Codes 001 and 010 execute as MUL.
- FSM states: IDLE, MUL, DIV, DONE.
- Start condition: IDLE and valid_i and ALUOp=00 and F[3]=1 and !flush_i. On start, capture the operands and funct3.
  - Normal start: go to MUL or DIV with iteration counter = 0.
  - Special case start: go directly to DONE with the result latched.
- Multiplier: unsigned radix-2 shift-add, 2·XLEN product, one bit per cycle.
- Divider: restoring, one quotient bit per cycle. Signed ops divide magnitudes, then fix signs.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Special cases (no iteration):
  - Divisor 0: quotient = all ones, remainder = dividend.
  - DIV/REM with 100…0 / all ones: quotient = 100…0, remainder = 0.
- MUL/DIV states go to DONE when counter = XLEN-1. DONE goes to IDLE unconditionally.
- `mdu_busy_o` = (IDLE and start condition) or state ∈ {MUL, DIV}. It is low in DONE.
- `mdu_done_o` = (state == DONE).
- `mdu_result_o` is registered. It updates on entry to DONE and holds until the next completion.
- `flush_i` in any state forces IDLE at the next edge, with no done pulse and the result unchanged. Flush has priority over start.
- Reset values: state IDLE, counter 0, `mdu_result_o` 0, `mdu_done_o` 0, `mdu_busy_o` 0 (valid_i low).

## Timing
- Cycle 0: MDU instruction presented, busy=1 combinationally. Start is sampled at the end of cycle 0.
- Normal op: cycles 1..XLEN in MUL/DIV, busy=1. Cycle XLEN+1 is DONE: busy=0, done=1, result valid. The pipeline advances at the end of that cycle.
- Special case: busy=1 in cycle 0 only; DONE in cycle 1.
- The instruction still present in EX during DONE does not restart the MDU, because the state is not IDLE.
- A back-to-back MDU instruction presented in the cycle after DONE starts normally from IDLE.
- Asynchronous reset mid-operation: outputs reach their reset values immediately, with no done pulse.

## Test plan
- Decode sweep: all ALUOp × funct3 × F[8]/F[3] combinations produce the codes listed above.
  - Check: ALUOp 01, F=0x105 → 0101.
  - Check: ALUOp 01, F=0x100 → 0011.
- MUL 7×6, XLEN=32: busy for 33 cycles, done in cycle 33, result 42, done high for exactly 1 cycle.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with busy for 1 cycle. DIV 0x80000000/0xFFFFFFFF → 0x80000000.
- Abort cases:
  - flush_i at cycle 10 of a DIV: IDLE next cycle, no done, previous result retained.
  - rst_i low at cycle 5 of a MUL: all outputs 0 immediately, then a clean restart after release.
